// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter funnelling NUM_REQ write requesters into one shared FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
  state_t                r_state, w_nxt;
  logic [PW-1:0]         r_ptr, w_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_hit, w_legal, w_grant, w_go;
  logic [FIFO_WIDTH-1:0] w_data;
  assign w_elig    = req & ~ack;
  assign w_legal   = !fifo_full && !(fifo_almostfull && wr_en);
  assign w_grant   = w_hit && w_legal;
  assign w_data    = req_data[int'(w_idx)*FIFO_WIDTH +: FIFO_WIDTH];
  assign w_ptr_nxt = PW'((int'(w_idx) + 1) % NUM_REQ);
  assign busy      = r_state != IDLE;
  // Round-robin search from r_ptr; descending scan so the closest eligible index wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_hit = 1'b1;
        w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  // Next state: idle without requests, stall when a write is blocked, active otherwise
  always_comb begin
    w_go  = |w_elig || r_state != IDLE;
    w_nxt = (!(|req) || !w_go) ? IDLE : w_legal ? ACTIVE : STALL;
  end
  // State, pointer and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      ack       <= '0;
      wr_en     <= 1'b0;
      data_in   <= '0;
      stall_cnt <= '0;
    end else begin
      r_state   <= w_nxt;
      r_ptr     <= w_grant ? w_ptr_nxt : r_ptr;
      ack       <= w_grant ? (NUM_REQ'(1) << w_idx) : '0;
      wr_en     <= w_grant;
      data_in   <= w_grant ? w_data : data_in;
      stall_cnt <= (r_state == STALL && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
endmodule
